// File: rtl/cmp_unit_arbiter_pkg.sv
// Shared types and constants for the compare-unit arbiter.
// State encoding, default sizes and the pointer-width helper.
package cmp_unit_arbiter_pkg;

    localparam int DEFAULT_NREQ  = 4;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bits needed to hold a requester index (at least 1).
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_NREQ);

endpackage

// File: rtl/cmp_unit_arbiter_if.sv
// Request/response bundle between requesters and the compare unit.
// master = requester side, slave = arbiter side.
interface cmp_unit_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [NREQ-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_diff;
    logic                  rsp_cout;
    logic                  rsp_ltu;
    logic                  rsp_lts;
    logic                  rsp_eq;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_diff,
        input  rsp_cout, rsp_ltu, rsp_lts, rsp_eq
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_diff,
        output rsp_cout, rsp_ltu, rsp_lts, rsp_eq
    );

endinterface

// File: rtl/cmp_unit_arbiter_rr_arbiter.sv
// Round-robin priority picker: first set request at or after ptr.
// Produces a one-hot grant and the winner's encoded index.
module cmp_unit_arbiter_rr_arbiter
    import cmp_unit_arbiter_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    // Scan ptr, ptr+1, ... wrapping at NREQ-1; first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (gnt == '0 && req[j]) begin
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/cmp_unit_arbiter.sv
// One shared WIDTH-bit subtract/compare unit, round-robin arbitrated.
// Sequence per op: grant (IDLE) -> compute (EXEC) -> hold result (RESP).
module cmp_unit_arbiter
    import cmp_unit_arbiter_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    cmp_unit_arbiter_if.slave  bus,
    output logic               busy
);

    localparam int PW = ptr_width(NREQ);

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [NREQ-1:0]  id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             cout_q, cout_d;
    logic             ltu_q, ltu_d;
    logic             lts_q, lts_d;
    logic             eq_q, eq_d;

    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH:0]   sum;
    logic             ovf;

    cmp_unit_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign ptr_nxt = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);

    // Select the winner's operands for capture at the grant edge.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = a_sel | bus.req_a[i*WIDTH +: WIDTH];
                b_sel = b_sel | bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Shared core: A + ~B + 1 with carry, plus signed overflow.
    assign sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    assign ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                 (sum[WIDTH-1] != a_q[WIDTH-1]);

    // Next-state and next-output logic for the grant/exec/resp sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        diff_d      = diff_q;
        cout_d      = cout_q;
        ltu_d       = ltu_q;
        lts_d       = lts_q;
        eq_d        = eq_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    id_d    = gnt;
                    ptr_d   = ptr_nxt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                diff_d      = sum[WIDTH-1:0];
                cout_d      = sum[WIDTH];
                ltu_d       = ~sum[WIDTH];
                lts_d       = sum[WIDTH-1] ^ ovf;
                eq_d        = (sum[WIDTH-1:0] == '0);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, pointer, operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            diff_q      <= '0;
            cout_q      <= 1'b0;
            ltu_q       <= 1'b0;
            lts_q       <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            diff_q      <= diff_d;
            cout_q      <= cout_d;
            ltu_q       <= ltu_d;
            lts_q       <= lts_d;
            eq_q        <= eq_d;
        end
    end

    // Grant is only offered while idle and out of reset.
    assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_diff  = diff_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_ltu   = ltu_q;
    assign bus.rsp_lts   = lts_q;
    assign bus.rsp_eq    = eq_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_unit_arbiter.sv
// Bench for cmp_unit_arbiter: directed cases, then random traffic
// compared against an arithmetic/round-robin reference model.
module tb_cmp_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    logic busy;

    int n_assert;
    int n_fail;
    int mptr;

    logic [WIDTH-1:0] opa [NREQ];
    logic [WIDTH-1:0] opb [NREQ];

    cmp_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    cmp_unit_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        bus.req_a = {opa[3], opa[2], opa[1], opa[0]};
        bus.req_b = {opb[3], opb[2], opb[1], opb[0]};
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_rsp(input string tag, input int w,
                             input logic [WIDTH-1:0] ea,
                             input logic [WIDTH-1:0] eb);
        logic [WIDTH-1:0] ediff;
        ediff = ea - eb;
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(1));
        check({tag, "_id"},    32'(bus.rsp_id),    32'(1) << w);
        check({tag, "_diff"},  32'(bus.rsp_diff),  32'(ediff));
        check({tag, "_cout"},  32'(bus.rsp_cout),  32'(ea >= eb));
        check({tag, "_ltu"},   32'(bus.rsp_ltu),   32'(ea < eb));
        check({tag, "_lts"},   32'(bus.rsp_lts),
              32'($signed(ea) < $signed(eb)));
        check({tag, "_eq"},    32'(bus.rsp_eq),    32'(ea == eb));
        check({tag, "_rdy0"},  32'(bus.req_ready), 32'(0));
    endtask

    // One full operation starting in IDLE; hold = stall cycles in RESP.
    task automatic do_op(input logic [NREQ-1:0] vmask, input int hold);
        int w;
        logic [WIDTH-1:0] ea, eb;
        pack();
        bus.req_valid = vmask;
        #1;
        w = model_pick(vmask);
        check("idle_busy", 32'(busy), 32'(0));
        check("grant", 32'(bus.req_ready), 32'(1) << w);
        ea   = opa[w];
        eb   = opb[w];
        mptr = (w + 1) % NREQ;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = WIDTH'($urandom);
            opb[i] = WIDTH'($urandom);
        end
        pack();
        bus.req_valid = NREQ'($urandom);
        bus.rsp_ready = (hold == 0);
        #1;
        check("exec_busy", 32'(busy), 32'(1));
        check("exec_rdy", 32'(bus.req_ready), 32'(0));
        check("exec_rspv", 32'(bus.rsp_valid), 32'(0));
        tick();
        check_rsp("resp", w, ea, eb);
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = '1;
            tick();
            check_rsp("hold", w, ea, eb);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("done_rspv", 32'(bus.rsp_valid), 32'(0));
        check("done_busy", 32'(busy), 32'(0));
        bus.req_valid = '0;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        mptr          = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        tick();
        tick();
        check("rst_rspv", 32'(bus.rsp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rdy", 32'(bus.req_ready), 32'(0));
        check("rst_id", 32'(bus.rsp_id), 32'(0));
        check("rst_diff", 32'(bus.rsp_diff), 32'(0));
        check("rst_flags", 32'({bus.rsp_cout, bus.rsp_ltu,
              bus.rsp_lts, bus.rsp_eq}), 32'(0));
        rst_n = 1'b1;
        tick();
        check("idle_norq", 32'(bus.req_ready), 32'(0));

        opa[0] = 16'h0005; opb[0] = 16'h0003;
        do_op(4'b0001, 0);
        opa[0] = 16'h8000; opb[0] = 16'h0001;
        do_op(4'b0001, 0);
        opa[0] = 16'h0001; opb[0] = 16'hFFFF;
        do_op(4'b0001, 0);
        opa[0] = 16'h1234; opb[0] = 16'h1234;
        do_op(4'b0001, 0);

        bus.rsp_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = WIDTH'($urandom);
                opb[i] = WIDTH'($urandom);
            end
            do_op(4'b1111, 0);
        end

        opa[2] = 16'h7FFF; opb[2] = 16'h8000;
        do_op(4'b0110, 5);

        opa[2] = 16'h00AA; opb[2] = 16'h0055;
        pack();
        bus.req_valid = 4'b0100;
        #1;
        check("prst_grant", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        check("prst_rspv", 32'(bus.rsp_valid), 32'(1));
        bus.req_valid = 4'b1111;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rspv", 32'(bus.rsp_valid), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_rdy", 32'(bus.req_ready), 32'(0));
        check("arst_id", 32'(bus.rsp_id), 32'(0));
        tick();
        tick();
        check("arst_hold", 32'(bus.rsp_valid), 32'(0));
        rst_n = 1'b1;
        mptr  = 0;
        bus.req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = WIDTH'($urandom);
            opb[i] = WIDTH'($urandom);
        end
        do_op(4'b1111, 0);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.req_valid = '0;
                bus.rsp_ready = 1'($urandom);
                tick();
                check("rnd_idle_busy", 32'(busy), 32'(0));
                check("rnd_idle_rspv", 32'(bus.rsp_valid), 32'(0));
            end
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = WIDTH'($urandom);
                opb[i] = ($urandom_range(0, 3) == 0) ? opa[i]
                                                    : WIDTH'($urandom);
            end
            do_op(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
